// File: rtl/stream_pkg.sv
// Shared definitions for the result streamer: FSM state encoding, frame header
// default and the bytes-per-element helper.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Each element is 2*width bits, rounded up to whole bytes.
    function automatic int bytesPerElem(input int width);
        return (2 * width + 7) / 8;
    endfunction

endpackage

// File: rtl/result_streamer.sv
// Captures a result vector on request and streams it to a byte-wide UART
// transmitter as HEADER, element bytes (MSB first) and an XOR checksum.
module result_streamer
    import stream_pkg::*;
#(
    parameter int         N      = 8,
    parameter int         WIDTH  = 8,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [2*N*WIDTH-1:0]   result,
    output logic                   ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   done
);

    localparam int EW        = 2 * WIDTH;
    localparam int BPE       = bytesPerElem(WIDTH);
    localparam int NDATA     = N * BPE;
    localparam int FRAME_LEN = NDATA + 2;
    localparam int IW        = $clog2(FRAME_LEN + 1);
    localparam int DW        = (NDATA > 1) ? $clog2(NDATA) : 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        byteIdx_q, byteIdx_d;
    logic [7:0]           chk_q, chk_d;
    logic [7:0]           txData_q, txData_d;
    logic [2*N*WIDTH-1:0] result_q;

    logic [7:0]           dataBytes [NDATA];
    logic [7:0]           curByte;
    logic [IW-1:0]        dataIdx;
    logic                 isDataByte;

    // Capture register is deliberately unreset; it only matters after a load.
    always_ff @(posedge clk) begin
        if (ready && load) begin
            result_q <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byteIdx_q <= '0;
            chk_q     <= 8'h00;
            txData_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            byteIdx_q <= byteIdx_d;
            chk_q     <= chk_d;
            txData_q  <= txData_d;
        end
    end

    // Split each element into zero-extended bytes, most significant byte first.
    always_comb begin
        logic [BPE*8-1:0] padded;
        padded = '0;
        for (int e = 0; e < N; e++) begin
            padded         = '0;
            padded[EW-1:0] = result_q[e*EW +: EW];
            for (int b = 0; b < BPE; b++) begin
                dataBytes[e*BPE + b] = padded[(BPE-1-b)*8 +: 8];
            end
        end
    end

    assign dataIdx    = byteIdx_q - IW'(1);
    assign isDataByte = (byteIdx_q != '0) && (byteIdx_q != IW'(FRAME_LEN - 1));

    always_comb begin
        curByte = HEADER;
        if (byteIdx_q == IW'(FRAME_LEN - 1)) begin
            curByte = chk_q;
        end else if (byteIdx_q != '0) begin
            curByte = dataBytes[dataIdx[DW-1:0]];
        end
    end

    // The new byte appears on tx_data exactly with its start pulse and is then held.
    assign tx_data = tx_start ? curByte : txData_q;

    always_comb begin
        state_d   = state_q;
        byteIdx_d = byteIdx_q;
        chk_d     = chk_q;
        txData_d  = txData_q;
        tx_start  = 1'b0;
        done      = 1'b0;
        ready     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    state_d   = SEND;
                    byteIdx_d = '0;
                    chk_d     = 8'h00;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    txData_d  = curByte;
                    byteIdx_d = byteIdx_q + IW'(1);
                    if (isDataByte) begin
                        chk_d = chk_q ^ curByte;
                    end
                    state_d = GUARD;
                end
            end
            // Busy is ignored here: the transmitter raises it one cycle late.
            GUARD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (byteIdx_q == IW'(FRAME_LEN)) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: frame-level reference model, UART busy
// model, directed scenarios plus randomized frames, and a 12-bit element instance.
module tb_result_streamer;

    localparam int N         = 8;
    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 18;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 load = 1'b0;
    logic [2*N*WIDTH-1:0] result = '0;
    logic                 ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy = 1'b0;
    logic                 done;

    logic                 load2 = 1'b0;
    logic [23:0]          result2 = '0;
    logic                 ready2;
    logic [7:0]           tx_data2;
    logic                 tx_start2;
    logic                 done2;

    int checks = 0;
    int fails  = 0;

    result_streamer #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .load(load), .result(result), .ready(ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .done(done)
    );

    result_streamer #(.N(2), .WIDTH(6)) dut12 (
        .clk(clk), .rst(rst), .load(load2), .result(result2), .ready(ready2),
        .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(1'b0), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame byte k derived directly from the frame format.
    function automatic logic [7:0] modelByte(input logic [2*N*WIDTH-1:0] v, input int k);
        logic [7:0]  x;
        logic [15:0] el;
        if (k == 0) return 8'hA5;
        if (k == FRAME_LEN - 1) begin
            x = 8'h00;
            for (int e = 0; e < N; e++) begin
                el = v[e*16 +: 16];
                x  = x ^ el[15:8] ^ el[7:0];
            end
            return x;
        end
        el = v[((k-1)/2)*16 +: 16];
        return ((k - 1) % 2 == 0) ? el[15:8] : el[7:0];
    endfunction

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    logic [7:0] got2[$];
    logic [7:0] lastData = 8'h00;
    bit         modelIdle = 1'b1;
    int         startCnt = 0;
    int         doneCnt = 0;
    int         done2Cnt = 0;
    int         cyc = 0;
    int         lastStartCyc = -100;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expQ.delete();
            modelIdle    = 1'b1;
            lastData     = 8'h00;
            lastStartCyc = -100;
        end else begin
            checkOutput("ready", 32'(ready), 32'(modelIdle));
            if (tx_start) begin
                startCnt++;
                gotQ.push_back(tx_data);
                checkOutput("start_while_busy", 32'(tx_busy), 0);
                checkOutput("start_spacing", 32'(cyc - lastStartCyc >= 3), 1);
                lastStartCyc = cyc;
                checkOutput("start_expected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
                lastData = tx_data;
            end else begin
                checkOutput("tx_data_hold", 32'(tx_data), 32'(lastData));
            end
            if (done) begin
                doneCnt++;
                checkOutput("done_frame_complete", expQ.size(), 0);
                checkOutput("done_in_frame", 32'(modelIdle), 0);
                checkOutput("done_with_start", 32'(tx_start), 0);
            end
            if (load && modelIdle) begin
                modelIdle = 1'b0;
                for (int k = 0; k < FRAME_LEN; k++) expQ.push_back(modelByte(result, k));
            end
            if (done) modelIdle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && tx_start2) got2.push_back(tx_data2);
        if (!rst && done2) done2Cnt++;
    end

    // Transmitter model: busy rises the cycle after a start and lasts busyLen cycles.
    int busyLen = 10;
    bit forceBusy = 1'b0;
    int seenStarts = 0;
    int busyCnt = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            busyCnt    = 0;
            seenStarts = startCnt;
        end else if (startCnt != seenStarts) begin
            seenStarts = startCnt;
            busyCnt    = busyLen;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
        tx_busy = forceBusy || (busyCnt > 0);
    end

    task automatic applyStimulus(input logic [2*N*WIDTH-1:0] vec);
        @(posedge clk);
        #1;
        result = vec;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (doneCnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("frame_timeout", 32'(doneCnt >= target), 1);
    endtask

    task automatic pulseLoadOnly();
        @(posedge clk);
        #1;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    logic [2*N*WIDTH-1:0] vecA, vecFF, vecB, vecR;
    int s0, d0, n;

    initial begin
        for (int e = 0; e < N; e++) vecA[e*16 +: 16] = 16'(e + 1);
        vecFF = '1;

        checkOutput("model_chk_seq", 32'(modelByte(vecA, 17)), 32'h08);
        checkOutput("model_byte2_seq", 32'(modelByte(vecA, 2)), 32'h01);
        checkOutput("model_chk_ff", 32'(modelByte(vecFF, 17)), 32'h00);

        #2 rst = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_tx_start", 32'(tx_start), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_tx_data", 32'(tx_data), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Sequential elements with a 10-cycle transmitter.
        gotQ.delete();
        s0 = startCnt; d0 = doneCnt;
        applyStimulus(vecA);
        checkOutput("hdr_latency_start", 32'(tx_start), 1);
        checkOutput("hdr_latency_data", 32'(tx_data), 32'hA5);
        waitDone(d0 + 1, 1000);
        repeat (5) @(posedge clk);
        checkOutput("seq_start_count", startCnt - s0, FRAME_LEN);
        checkOutput("seq_done_once", doneCnt - d0, 1);
        checkOutput("seq_len", gotQ.size(), FRAME_LEN);
        if (gotQ.size() == FRAME_LEN) begin
            checkOutput("seq_b1", 32'(gotQ[1]), 32'h00);
            checkOutput("seq_b2", 32'(gotQ[2]), 32'h01);
            checkOutput("seq_b16", 32'(gotQ[16]), 32'h08);
            checkOutput("seq_chk", 32'(gotQ[17]), 32'h08);
        end

        // All-ones elements.
        gotQ.delete();
        d0 = doneCnt;
        applyStimulus(vecFF);
        waitDone(d0 + 1, 1000);
        checkOutput("ff_len", gotQ.size(), FRAME_LEN);
        if (gotQ.size() == FRAME_LEN) begin
            checkOutput("ff_b9", 32'(gotQ[9]), 32'hFF);
            checkOutput("ff_chk", 32'(gotQ[17]), 32'h00);
        end

        // Loads during a frame and result changes after capture are ignored.
        for (int i = 0; i < 2*N*WIDTH/32; i++) vecB[i*32 +: 32] = $urandom;
        gotQ.delete();
        d0 = doneCnt;
        applyStimulus(vecB);
        repeat (20) @(posedge clk);
        result = ~vecB;
        pulseLoadOnly();
        repeat (30) @(posedge clk);
        pulseLoadOnly();
        waitDone(d0 + 1, 1000);
        repeat (3) @(posedge clk);
        checkOutput("ignore_done_once", doneCnt - d0, 1);
        checkOutput("ignore_len", gotQ.size(), FRAME_LEN);
        if (gotQ.size() > 1) checkOutput("ignore_b1", 32'(gotQ[1]), 32'(vecB[15:8]));

        // Transmitter busy before the header.
        forceBusy = 1'b1;
        repeat (2) @(posedge clk);
        gotQ.delete();
        s0 = startCnt; d0 = doneCnt;
        applyStimulus(vecA);
        repeat (50) @(posedge clk);
        checkOutput("busy_no_start", startCnt - s0, 0);
        forceBusy = 1'b0;
        waitDone(d0 + 1, 1000);
        checkOutput("busy_start_count", startCnt - s0, FRAME_LEN);
        if (gotQ.size() > 1) begin
            checkOutput("busy_hdr", 32'(gotQ[0]), 32'hA5);
            checkOutput("busy_hdr_once", 32'(gotQ[1]), 32'h00);
        end

        // Reset after the fifth byte, then a fresh frame.
        s0 = startCnt; d0 = doneCnt;
        applyStimulus(vecFF);
        n = 0;
        while (startCnt < s0 + 5 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checkOutput("mid_reset_reach", 32'(startCnt >= s0 + 5), 1);
        #3 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 32'(ready), 1);
        checkOutput("mid_rst_tx_start", 32'(tx_start), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        checkOutput("mid_rst_tx_data", 32'(tx_data), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("mid_rst_no_done", doneCnt - d0, 0);
        gotQ.delete();
        applyStimulus(vecA);
        waitDone(d0 + 1, 1000);
        checkOutput("fresh_len", gotQ.size(), FRAME_LEN);
        if (gotQ.size() > 0) checkOutput("fresh_hdr", 32'(gotQ[0]), 32'hA5);

        // Randomized frames with varying transmitter speed.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 2*N*WIDTH/32; i++) vecR[i*32 +: 32] = $urandom;
            busyLen = $urandom_range(0, 12);
            d0 = doneCnt;
            applyStimulus(vecR);
            waitDone(d0 + 1, 1500);
        end
        busyLen = 10;

        // 12-bit elements: 12'hABC and 12'h123.
        got2.delete();
        d0 = done2Cnt;
        @(posedge clk);
        #1;
        result2 = {12'h123, 12'hABC};
        load2   = 1'b1;
        @(posedge clk);
        #1;
        load2 = 1'b0;
        n = 0;
        while (done2Cnt == d0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("w6_done", done2Cnt - d0, 1);
        checkOutput("w6_len", got2.size(), 6);
        if (got2.size() == 6) begin
            checkOutput("w6_hdr", 32'(got2[0]), 32'hA5);
            checkOutput("w6_hi", 32'(got2[1]), 32'h0A);
            checkOutput("w6_lo", 32'(got2[2]), 32'hBC);
            checkOutput("w6_e1_hi", 32'(got2[3]), 32'h01);
            checkOutput("w6_e1_lo", 32'(got2[4]), 32'h23);
            checkOutput("w6_chk", 32'(got2[5]), 32'h94);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 SHALL have parameter N, default 8, meaning element count of the result vector.
REQ-002 SHALL have parameter WIDTH, default 8, meaning input-operand width; each result element is 2*WIDTH bits.
REQ-003 SHALL have parameter HEADER, default 8'hA5, meaning frame start byte.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load  input  1  one-cycle request to capture result and send a frame.
REQ-007 SHALL have port result  input  2*N*WIDTH  element i at bits [(i+1)*2*WIDTH-1 : i*2*WIDTH].
REQ-008 SHALL have port ready  output  1  high only in IDLE; load is accepted only when ready is high.
REQ-009 SHALL have port tx_data  output  8  byte to byte-wide UART transmitter.
REQ-010 SHALL have port tx_start  output  1  one-cycle start pulse to transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL define BPE = ceil(2*WIDTH/8) bytes per element; frame length = 1 + N*BPE + 1 bytes (18 at defaults).
REQ-014 SHALL, on load with ready high, register result internally in that cycle; later changes on result do not affect the frame.
REQ-015 SHALL ignore load while ready is low; no capture, no state change.
REQ-016 SHALL send bytes in order: HEADER; element 0..N-1, each MSB byte first, top byte zero-extended when 2*WIDTH is not a multiple of 8; checksum.
REQ-017 SHALL compute checksum as XOR of all element bytes, excluding HEADER, accumulated as bytes are issued.
REQ-018 SHALL implement states IDLE, SEND, GUARD, WAIT. Transitions: IDLE->SEND on accepted load; SEND->GUARD unconditionally; GUARD->WAIT unconditionally; WAIT->SEND when tx_busy low and bytes remain; WAIT->IDLE when tx_busy low and checksum already sent.
REQ-019 SHALL, in SEND, assert tx_start for exactly one cycle, and advance the byte index only if tx_busy is low; if tx_busy is high, stay in SEND with tx_start low.
REQ-020 SHALL hold tx_data stable from the tx_start cycle until the next tx_start.
REQ-021 SHALL ignore tx_busy in GUARD, covering the transmitter's one-cycle busy-rise latency.
REQ-022 SHALL give minimum latency: load at cycle t -> HEADER tx_start at t+1 when tx_busy is low; successive tx_start pulses are at least 3 cycles apart.
REQ-023 SHALL pulse done in the WAIT->IDLE cycle; ready is high from the following cycle.
REQ-024 SHALL never assert tx_start and done in the same cycle.

Reset
REQ-025 SHALL, on rst (including mid-frame), force state IDLE, ready=1, tx_start=0, done=0, tx_data=8'h00, byte index=0, checksum=0 immediately; a partial frame is abandoned and not resumed.
REQ-026 SHALL leave the captured result register unreset; it is don't-care until the next load.

Structure
REQ-027 SHALL place the state encoding, the HEADER default and a BPE helper function in shared package stream_pkg.
REQ-028 SHALL be a single module with no sub-module; byte selection is an indexed mux on the captured vector.

Verification
REQ-029 SHALL test N=8, WIDTH=8, elements 16'h0001..16'h0008, tx_busy model 10 cycles per byte -> bytes A5,00,01,00,02,...,00,08,08; done pulses once; 18 tx_start pulses.
REQ-030 SHALL test all elements 16'hFFFF -> 16 data bytes FF, checksum 00.
REQ-031 SHALL test load pulses during an active frame, with result changed after capture -> ignored; frame content equals the captured value.
REQ-032 SHALL test tx_busy held high 50 cycles before the HEADER -> no tx_start until tx_busy falls; HEADER then sent exactly once.
REQ-033 SHALL test rst asserted after the 5th byte -> outputs at reset values immediately; a new load sends a complete fresh frame starting A5.
REQ-034 SHALL test WIDTH=6 (12-bit elements), element 12'hABC -> bytes 0A, BC.
